// File: rtl/tl_router_param.sv
// Parameterised 1-to-N_CH word router with an input FIFO and per-channel output FIFOs.
// Latency: 1 cycle push into the input FIFO, 1 cycle move to the channel, read data registered 1 cycle after pop.
// Backpressure: the head stalls while its channel is at the high threshold; pauseIn warns; overflow is sticky.

module tl_fifo #(
   parameter int W     = 12,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_vld,
   input  logic [W-1:0]  wr_dat,
   input  logic          rd_rdy,
   output logic [W-1:0]  rd_dat,
   output logic [AW:0]   cnt,
   output logic [AW:0]   cnt_nxt
);
   // Plain circular buffer; the caller only writes when not full and reads when not empty.
   // Latency: write visible at rd_dat one cycle later when the FIFO was empty.
   // Backpressure: none internally; the caller gates wr_vld and rd_rdy.
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   assign rd_dat = mem[rptr];

   always_comb begin
      cnt_nxt = cnt;
      if (wr_vld && !rd_rdy)
         cnt_nxt = cnt + CNT_ONE;
      else if (!wr_vld && rd_rdy)
         cnt_nxt = cnt - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr_vld)
            wptr <= wptr + PTR_ONE;
         if (rd_rdy)
            rptr <= rptr + PTR_ONE;
         cnt <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_vld)
         mem[wptr] <= wr_dat;
   end
endmodule

module tl_router_param #(
   parameter  int DATA_W   = 12,
   parameter  int DEPTH    = 8,
   parameter  int N_CH     = 4,
   parameter  int DEST_LSB = 8,
   parameter  int CNT_W    = 5,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     init,
   input  logic [AW-1:0]            Umbral_alto,
   input  logic [AW-1:0]            Umbral_bajo,
   input  logic                     pushIn,
   input  logic [DATA_W-1:0]        dataIn,
   input  logic [N_CH-1:0]          popOut,
   output logic [N_CH*DATA_W-1:0]   dataOut,
   output logic [N_CH-1:0]          almost_full,
   output logic [N_CH-1:0]          almost_empty,
   output logic [N_CH-1:0]          empty,
   output logic                     pauseIn,
   output logic                     errorIn,
   input  logic                     req,
   input  logic [CW:0]              idx,
   output logic [CNT_W-1:0]         counterOut,
   output logic                     counterValid,
   output logic [2:0]               state
);
   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [CW:0]    IDX_SUM  = (CW+1)'(N_CH);
   localparam logic [CNT_W-1:0] CTR_ONE = 1;

   state_t            st_q, st_d;
   logic [AW-1:0]     thr_hi_q, thr_lo_q;
   logic [AW-1:0]     thr_hi_nxt, thr_lo_nxt;

   logic [DATA_W-1:0] in_dat;
   logic [AW:0]       in_cnt, in_cnt_nxt;
   logic [CW-1:0]     dest;
   logic [AW:0]       dst_cnt;
   logic              blk, push_ok, overflow, move, any_busy;

   logic [DATA_W-1:0] out_dat     [N_CH];
   logic [AW:0]       out_cnt     [N_CH];
   logic [AW:0]       out_cnt_nxt [N_CH];
   logic [N_CH-1:0]   move_k, pop_ok;
   logic [CNT_W-1:0]  ctr [N_CH];
   logic [CNT_W-1:0]  ctr_sum;

   assign state = st_q;

   // Thresholds seen at the next edge, so flags registered while in INIT already use the new values.
   assign thr_hi_nxt = (st_q == ST_INIT) ? Umbral_alto : thr_hi_q;
   assign thr_lo_nxt = (st_q == ST_INIT) ? Umbral_bajo : thr_lo_q;

   assign blk      = (st_q == ST_INIT) || (st_q == ST_RESET);
   assign push_ok  = pushIn && (in_cnt != FULL_CNT) && !blk;
   assign overflow = pushIn && (in_cnt == FULL_CNT) && !blk;
   assign dest     = in_dat[DEST_LSB +: CW];
   assign dst_cnt  = out_cnt[dest];
   assign move     = !blk && (in_cnt != '0) && (dst_cnt < {1'b0, thr_hi_q}) && (dst_cnt != FULL_CNT);

   tl_fifo #(.W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_in_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_vld  (push_ok),
      .wr_dat  (dataIn),
      .rd_rdy  (move),
      .rd_dat  (in_dat),
      .cnt     (in_cnt),
      .cnt_nxt (in_cnt_nxt)
   );

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      tl_fifo #(.W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_out_fifo (
         .clk     (clk),
         .reset   (reset),
         .wr_vld  (move_k[g]),
         .wr_dat  (in_dat),
         .rd_rdy  (pop_ok[g]),
         .rd_dat  (out_dat[g]),
         .cnt     (out_cnt[g]),
         .cnt_nxt (out_cnt_nxt[g])
      );
   end

   always_comb begin
      move_k   = '0;
      pop_ok   = '0;
      ctr_sum  = '0;
      any_busy = (in_cnt != '0);
      for (int k = 0; k < N_CH; k++) begin
         move_k[k] = move && (dest == CW'(k));
         pop_ok[k] = popOut[k] && (out_cnt[k] != '0);
         ctr_sum   = ctr_sum + ctr[k];
         if (out_cnt[k] != '0)
            any_busy = 1'b1;
      end
   end

   always_comb begin
      st_d = st_q;
      if (st_q == ST_ERROR)
         st_d = ST_ERROR;
      else if (overflow)
         st_d = ST_ERROR;
      else if (init)
         st_d = ST_INIT;
      else begin
         case (st_q)
            ST_RESET:  st_d = ST_INIT;
            ST_INIT:   st_d = ST_IDLE;
            ST_IDLE:   if (any_busy) st_d = ST_ACTIVE;
            ST_ACTIVE: if (!any_busy) st_d = ST_IDLE;
            default:   st_d = ST_RESET;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q     <= ST_RESET;
         thr_hi_q <= '0;
         thr_lo_q <= '0;
         pauseIn  <= 1'b0;
         errorIn  <= 1'b0;
      end else begin
         st_q     <= st_d;
         thr_hi_q <= thr_hi_nxt;
         thr_lo_q <= thr_lo_nxt;
         pauseIn  <= (in_cnt_nxt >= {1'b0, thr_hi_nxt});
         errorIn  <= errorIn | overflow;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         dataOut      <= '0;
         almost_full  <= '0;
         almost_empty <= '1;
         empty        <= '1;
         for (int k = 0; k < N_CH; k++)
            ctr[k] <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (pop_ok[k]) begin
               dataOut[k*DATA_W +: DATA_W] <= out_dat[k];
               ctr[k]                      <= ctr[k] + CTR_ONE;
            end
            almost_full[k]  <= (out_cnt_nxt[k] >= {1'b0, thr_hi_nxt});
            almost_empty[k] <= (out_cnt_nxt[k] <= {1'b0, thr_lo_nxt});
            empty[k]        <= (out_cnt_nxt[k] == '0);
         end
      end
   end

   // Readout samples the counters before this edge's increment.
   always_ff @(posedge clk) begin
      if (!reset) begin
         counterValid <= 1'b0;
         counterOut   <= '0;
      end else begin
         counterValid <= req && (st_q == ST_IDLE);
         counterOut   <= '0;
         if (req && (st_q == ST_IDLE)) begin
            if (idx < IDX_SUM)
               counterOut <= ctr[idx[CW-1:0]];
            else if (idx == IDX_SUM)
               counterOut <= ctr_sum;
         end
      end
   end
endmodule

// File: tb/tb_tl_router_param.sv
// Directed bench: threshold latching, routing, stall at the high threshold, overflow, readout and counter wrap.
module tb_tl_router_param;
   localparam int DATA_W = 12;
   localparam int N_CH   = 4;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   init;
   logic [2:0]             Umbral_alto;
   logic [2:0]             Umbral_bajo;
   logic                   pushIn;
   logic [DATA_W-1:0]      dataIn;
   logic [N_CH-1:0]        popOut;
   logic [N_CH*DATA_W-1:0] dataOut;
   logic [N_CH-1:0]        almost_full;
   logic [N_CH-1:0]        almost_empty;
   logic [N_CH-1:0]        empty;
   logic                   pauseIn;
   logic                   errorIn;
   logic                   req;
   logic [2:0]             idx;
   logic [4:0]             counterOut;
   logic                   counterValid;
   logic [2:0]             state;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tl_router_param dut (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .Umbral_alto  (Umbral_alto),
      .Umbral_bajo  (Umbral_bajo),
      .pushIn       (pushIn),
      .dataIn       (dataIn),
      .popOut       (popOut),
      .dataOut      (dataOut),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .empty        (empty),
      .pauseIn      (pauseIn),
      .errorIn      (errorIn),
      .req          (req),
      .idx          (idx),
      .counterOut   (counterOut),
      .counterValid (counterValid),
      .state        (state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      init   = 1'b0;
      pushIn = 1'b0;
      popOut = '0;
      req    = 1'b0;
      tick();
      tick();
      reset  = 1'b1;
   endtask

   task automatic do_init(input logic [2:0] hi, input logic [2:0] lo);
      Umbral_alto = hi;
      Umbral_bajo = lo;
      init = 1'b1;
      tick();
      tick();
      init = 1'b0;
      tick();
   endtask

   task automatic push(input logic [DATA_W-1:0] w);
      dataIn = w;
      pushIn = 1'b1;
      tick();
      pushIn = 1'b0;
   endtask

   task automatic send_and_pop(input logic [DATA_W-1:0] w, input int k);
      push(w);
      tick();
      popOut = N_CH'(1 << k);
      tick();
      popOut = '0;
   endtask

   task automatic readout(input int i, input logic [4:0] exp);
      req = 1'b1;
      idx = 3'(i);
      tick();
      req = 1'b0;
      check("rd_valid", counterValid, 1);
      check("rd_value", counterOut, exp);
   endtask

   initial begin
      reset = 1'b0; init = 1'b0; Umbral_alto = '0; Umbral_bajo = '0;
      pushIn = 1'b0; dataIn = '0; popOut = '0; req = 1'b0; idx = '0;

      // reset values
      tick();
      tick();
      check("rst_state", state, 0);
      check("rst_empty", empty, 4'hF);
      check("rst_aempty", almost_empty, 4'hF);
      check("rst_afull", almost_full, 0);
      check("rst_pause", pauseIn, 0);
      check("rst_error", errorIn, 0);
      check("rst_cvalid", counterValid, 0);
      check("rst_cout", counterOut, 0);
      check("rst_dout", dataOut, 0);

      // init sequence and threshold latch
      reset = 1'b1;
      Umbral_alto = 3'd6; Umbral_bajo = 3'd0; init = 1'b1;
      tick();
      check("st_init", state, 1);
      tick();
      init = 1'b0;
      tick();
      check("st_idle", state, 2);
      check("idle_aempty", almost_empty, 4'hF);
      check("idle_afull", almost_full, 0);
      Umbral_alto = 3'd2;

      // one word per channel
      push(12'h001); tick();
      push(12'h102); tick();
      push(12'h203); tick();
      push(12'h304); tick();
      tick();
      check("route_empty", empty, 4'h0);
      check("route_aempty", almost_empty, 4'h0);
      check("route_afull", almost_full, 4'h0);
      check("route_active", state, 3);
      popOut = 4'hF;
      tick();
      popOut = '0;
      check("route_dout", dataOut, 48'h304203102001);
      check("route_drained", empty, 4'hF);
      tick();
      check("route_idle", state, 2);

      // stall at the latched high threshold of 6, port value 2 ignored
      for (int i = 0; i < 8; i++) begin
         dataIn = 12'h0A0 + 12'(i);
         pushIn = 1'b1;
         tick();
      end
      pushIn = 1'b0;
      tick();
      check("stall_afull", almost_full, 4'b0001);
      check("stall_empty", empty, 4'b1110);
      check("stall_pause", pauseIn, 0);
      popOut = 4'b0001;
      tick();
      popOut = '0;
      check("stall_pop_dout", dataOut[11:0], 12'h0A0);
      check("stall_pop_afull", almost_full[0], 0);
      tick();
      check("stall_refill", almost_full[0], 1);
      popOut = 4'b0001;
      for (int i = 0; i < 7; i++) tick();
      popOut = '0;
      check("stall_last", dataOut[11:0], 12'h0A7);
      check("stall_drained", empty, 4'hF);
      tick();
      tick();
      check("stall_idle", state, 2);

      // pop on empty channel, readouts
      popOut = 4'b0100;
      tick();
      popOut = '0;
      check("pop_empty_dout", dataOut[35:24], 12'h203);
      readout(2, 5'd1);
      readout(0, 5'd9);
      readout(4, 5'd12);
      readout(5, 5'd0);
      tick();
      check("rd_idle_valid", counterValid, 0);

      // counters 7 and 3
      do_reset();
      check("rst2_dout", dataOut, 0);
      check("rst2_empty", empty, 4'hF);
      do_init(3'd6, 3'd0);
      check("init2_idle", state, 2);
      for (int i = 0; i < 7; i++) send_and_pop(12'h010 + 12'(i), 0);
      for (int i = 0; i < 3; i++) send_and_pop(12'h110 + 12'(i), 1);
      tick();
      tick();
      check("cnt_idle", state, 2);
      check("cnt_dout0", dataOut[11:0], 12'h016);
      check("cnt_dout1", dataOut[23:12], 12'h112);
      readout(0, 5'd7);
      readout(1, 5'd3);
      readout(4, 5'd10);
      readout(7, 5'd0);
      push(12'h300);
      tick();
      check("act_state", state, 3);
      req = 1'b1; idx = 3'd0;
      tick();
      req = 1'b0;
      check("act_cvalid", counterValid, 0);
      check("act_cout", counterOut, 0);

      // counter wrap
      do_reset();
      do_init(3'd6, 3'd0);
      popOut = 4'b0100;
      tick();
      popOut = '0;
      check("wrap_empty_dout", dataOut[35:24], 0);
      for (int i = 0; i < 33; i++) send_and_pop(12'(i), 0);
      tick();
      tick();
      check("wrap_dout", dataOut[11:0], 12'h020);
      readout(0, 5'd1);
      readout(2, 5'd0);
      readout(4, 5'd1);

      // overflow with high threshold 0 (no moves)
      do_reset();
      do_init(3'd0, 3'd0);
      check("ovf_afull", almost_full, 4'hF);
      for (int i = 0; i < 8; i++) begin
         dataIn = 12'h0C0 + 12'(i);
         pushIn = 1'b1;
         tick();
      end
      check("ovf_noerr", errorIn, 0);
      check("ovf_pause", pauseIn, 1);
      dataIn = 12'h0C8;
      tick();
      pushIn = 1'b0;
      check("ovf_err", errorIn, 1);
      check("ovf_state", state, 4);
      init = 1'b1;
      tick();
      init = 1'b0;
      tick();
      check("ovf_hold_state", state, 4);
      check("ovf_hold_err", errorIn, 1);
      do_reset();
      check("ovf_rst_state", state, 0);
      check("ovf_rst_err", errorIn, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
